// File: rtl/bus_memory_if.sv
// CPU bus + program-loader signal bundle for bus_memory.
// master = CPU/loader side, slave = bus_memory.
interface bus_memory_if;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        cpu_reset;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_busy;
    logic        ld_err;

    modport master (
        output addr, we, wdata, ld_start, ld_valid, ld_data, ld_last,
        input  rdata, cpu_reset, ld_ready, ld_busy, ld_err
    );

    modport slave (
        input  addr, we, wdata, ld_start, ld_valid, ld_data, ld_last,
        output rdata, cpu_reset, ld_ready, ld_busy, ld_err
    );
endinterface

// File: rtl/bus_memory.sv
// Memory-side responder for the CPU bus: RAM, status register and a byte-stream
// program loader. Optional cycle timer at 0xFF02/0xFF03 via BUS_MEMORY_TIMER_EN.
module bus_memory #(
    parameter int          RAM_AW    = 10,
    parameter logic [7:0]  FILL_BYTE = 8'hEA
) (
    input  logic         clk,
    input  logic         reset,
    bus_memory_if.slave  bus
);
    localparam int DEPTH = 2 ** RAM_AW;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RELEASE} state_t;

    state_t            state_q, state_d;
    logic [RAM_AW:0]   ptr;
    logic              ld_err_q;
    logic              fsm_cpu_rst, fsm_ready, fsm_busy;
    logic              in_ram, cpu_wr, beat;
    logic [7:0]        mem [0:DEPTH-1];

    assign in_ram = (bus.addr >> RAM_AW) == 16'd0;
    assign cpu_wr = (state_q == S_IDLE) && bus.we;
    assign beat   = (state_q == S_LOAD) && bus.ld_valid;

    always_comb begin
        state_d     = state_q;
        fsm_cpu_rst = 1'b0;
        fsm_ready   = 1'b0;
        fsm_busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ld_start) state_d = S_LOAD;
            end
            S_LOAD: begin
                fsm_cpu_rst = 1'b1;
                fsm_ready   = 1'b1;
                fsm_busy    = 1'b1;
                if (bus.ld_valid && bus.ld_last) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                fsm_cpu_rst = 1'b1;
                fsm_busy    = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // The CPU must stay in reset while our own reset is asserted, even though
    // the FSM sits in IDLE then.
    assign bus.cpu_reset = reset | fsm_cpu_rst;
    assign bus.ld_ready  = fsm_ready;
    assign bus.ld_busy   = fsm_busy;
    assign bus.ld_err    = ld_err_q;

    // ptr saturates at DEPTH: its top bit marks "RAM full", later beats are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            ld_err_q <= 1'b0;
        end else if (state_q == S_IDLE && bus.ld_start) begin
            ptr      <= '0;
            ld_err_q <= 1'b0;
        end else if (beat) begin
            if (ptr[RAM_AW]) ld_err_q <= 1'b1;
            else             ptr      <= ptr + 1'b1;
        end else if (cpu_wr && bus.addr == 16'hFF00 && bus.wdata[1]) begin
            ld_err_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (beat && !ptr[RAM_AW])
            mem[ptr[RAM_AW-1:0]] <= bus.ld_data;
        else if (cpu_wr && in_ram)
            mem[bus.addr[RAM_AW-1:0]] <= bus.wdata;
    end

`ifdef BUS_MEMORY_TIMER_EN
    logic [15:0] tmr;
    logic [7:0]  tmr_hi;

    // Reading the low byte latches the high byte so a LO-then-HI read pair is coherent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr    <= '0;
            tmr_hi <= '0;
        end else if (cpu_wr && (bus.addr == 16'hFF02 || bus.addr == 16'hFF03)) begin
            tmr    <= '0;
            tmr_hi <= '0;
        end else begin
            tmr <= tmr + 16'd1;
            if (state_q == S_IDLE && !bus.we && bus.addr == 16'hFF02)
                tmr_hi <= tmr[15:8];
        end
    end
`endif

    always_comb begin
        bus.rdata = FILL_BYTE;
        if (in_ram)
            bus.rdata = mem[bus.addr[RAM_AW-1:0]];
        else if (bus.addr == 16'hFF00)
            bus.rdata = {6'b0, ld_err_q, fsm_busy};
`ifdef BUS_MEMORY_TIMER_EN
        else if (bus.addr == 16'hFF02)
            bus.rdata = tmr[7:0];
        else if (bus.addr == 16'hFF03)
            bus.rdata = tmr_hi;
`endif
    end
endmodule

// File: tb/tb_bus_memory.sv
// Self-checking bench for bus_memory: vector table, directed loader sequences,
// and randomized CPU traffic against an array-based memory model.
module tb_bus_memory;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b1;

    bus_memory_if bus ();

    bus_memory #(.RAM_AW(AW), .FILL_BYTE(8'hEA)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;

    logic [7:0] model_mem   [DEPTH];
    bit         model_known [DEPTH];
    bit         model_err;
    int         model_ptr;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [15:0] a, input bit busy);
        if (a < DEPTH)          return model_mem[a];
        if (a == 16'hFF00)      return {6'b0, model_err, busy};
        return 8'hEA;
    endfunction

    task automatic check_read(input string name, input logic [15:0] a);
        bus.addr = a;
        bus.we   = 1'b0;
        #1;
        if (a < DEPTH && !model_known[a]) return;
        check(name, bus.rdata, model_read(a, 1'b0));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_cpu_write(input logic [15:0] a, input logic [7:0] d);
        if (a < DEPTH) begin
            model_mem[a]   = d;
            model_known[a] = 1'b1;
        end
        if (a == 16'hFF00 && d[1]) model_err = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input bit idle);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        cycle();
        bus.we    = 1'b0;
        if (idle) model_cpu_write(a, d);
    endtask

    task automatic start_load();
        bus.ld_start = 1'b1;
        cycle();
        bus.ld_start = 1'b0;
        model_err = 1'b0;
        model_ptr = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        cycle();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        if (model_ptr < DEPTH) begin
            model_mem[model_ptr]   = d;
            model_known[model_ptr] = 1'b1;
            model_ptr++;
        end else begin
            model_err = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        bit          w;

        bus.addr = 16'h0000; bus.we = 1'b0; bus.wdata = 8'h00;
        bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = 8'h00; bus.ld_last = 1'b0;
        model_err = 1'b0;
        model_ptr = 0;
        for (int i = 0; i < DEPTH; i++) model_known[i] = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("cpu_reset_in_reset", bus.cpu_reset, 1);
        reset = 1'b0;
        #1;
        check("cpu_reset_after_reset", bus.cpu_reset, 0);
        check("ld_busy_reset", bus.ld_busy, 0);
        check("ld_ready_reset", bus.ld_ready, 0);
        check("ld_err_reset", bus.ld_err, 0);

        // Vector table: drive, clock, then read the same address back
        tbl[0] = '{16'h0400, 1'b0, 8'h00, 8'hEA};
        tbl[1] = '{16'hFF01, 1'b0, 8'h00, 8'hEA};
        tbl[2] = '{16'hFF00, 1'b0, 8'h00, 8'h00};
        tbl[3] = '{16'hFFFF, 1'b0, 8'h00, 8'hEA};
        tbl[4] = '{16'h0010, 1'b1, 8'h5A, 8'h5A};
        tbl[5] = '{16'h03FF, 1'b1, 8'h77, 8'h77};
        tbl[6] = '{16'h0400, 1'b1, 8'h11, 8'hEA};
        tbl[7] = '{16'h8010, 1'b1, 8'h22, 8'hEA};
        tbl[8] = '{16'hFF01, 1'b1, 8'h33, 8'hEA};
        tbl[9] = '{16'h0010, 1'b0, 8'h00, 8'h5A};
        for (int i = 0; i < 10; i++) begin
            bus.addr  = tbl[i].addr;
            bus.we    = tbl[i].we;
            bus.wdata = tbl[i].wdata;
            cycle();
            bus.we = 1'b0;
            if (tbl[i].we) model_cpu_write(tbl[i].addr, tbl[i].wdata);
            #1;
            check($sformatf("tbl[%0d]", i), bus.rdata, tbl[i].exp);
        end

        // Basic load with a 2-cycle valid gap
        start_load();
        check("load_cpu_reset", bus.cpu_reset, 1);
        check("load_ready", bus.ld_ready, 1);
        check("load_busy", bus.ld_busy, 1);
        send_byte(8'hA9, 1'b0);
        send_byte(8'h05, 1'b0);
        cycle();
        cycle();
        check("gap_ready", bus.ld_ready, 1);
        check("gap_cpu_reset", bus.cpu_reset, 1);
        send_byte(8'h69, 1'b0);
        send_byte(8'h03, 1'b1);
        check("release_cpu_reset", bus.cpu_reset, 1);
        check("release_busy", bus.ld_busy, 1);
        check("release_ready", bus.ld_ready, 0);
        cycle();
        check("post_release_cpu_reset", bus.cpu_reset, 0);
        check("post_release_busy", bus.ld_busy, 0);
        check("post_release_err", bus.ld_err, 0);
        for (int i = 0; i < 4; i++) check_read($sformatf("load_mem[%0d]", i), 16'(i));

        // CPU write, then blocked write during LOAD and ignored re-start
        cpu_write(16'h0010, 8'h5A, 1'b1);
        check_read("cpu_wr_0010", 16'h0010);
        start_load();
        cpu_write(16'h0010, 8'hC3, 1'b0);
        send_byte(8'h4C, 1'b0);
        bus.ld_start = 1'b1;
        send_byte(8'h4D, 1'b1);
        bus.ld_start = 1'b0;
        cycle();
        check_read("load_blocks_cpu_wr", 16'h0010);
        check_read("restart_ignored_mem1", 16'h0001);

        // Overflow: DEPTH+2 bytes
        start_load();
        for (int i = 0; i < DEPTH + 2; i++)
            send_byte(8'((i * 7 + 3) ^ (i >> 8)) ^ (i >= DEPTH ? 8'hFF : 8'h00), i == DEPTH + 1);
        check("ovf_err", bus.ld_err, 1);
        cycle();
        check_read("ovf_mem0", 16'h0000);
        check_read("ovf_mem_last", 16'(DEPTH - 1));
        check_read("ovf_status", 16'hFF00);
        check("ovf_status_val", bus.rdata, 8'h02);

        // Random CPU traffic against the model (all RAM is known now)
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6: a = 16'($urandom_range(0, DEPTH - 1));
                7:       a = 16'hFF00;
                default: a = 16'($urandom);
            endcase
            if (a == 16'hFF02 || a == 16'hFF03) a = 16'hFFFF;
            w = ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
            if (a == 16'hFF00 && w) d[1] = ($urandom_range(0, 3) == 0);
            bus.addr = a; bus.we = w; bus.wdata = d;
            #1;
            check("rand_read", bus.rdata, model_read(a, 1'b0));
            cycle();
            if (w) model_cpu_write(a, d);
        end
        bus.we = 1'b0;

        cpu_write(16'hFF00, 8'h02, 1'b1);
        check_read("err_clear", 16'hFF00);
        check("err_clear_val", bus.rdata, 8'h00);

        // Async reset two bytes into a load
        start_load();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        reset = 1'b1;
        #1;
        check("arst_busy", bus.ld_busy, 0);
        check("arst_cpu_reset", bus.cpu_reset, 1);
        cycle();
        reset = 1'b0;
        model_err = 1'b0;
        cycle();
        check("arst_idle_cpu_reset", bus.cpu_reset, 0);
        check("arst_idle_ready", bus.ld_ready, 0);
        check_read("arst_mem0", 16'h0000);
        check_read("arst_mem1", 16'h0001);

        // Timer
`ifdef BUS_MEMORY_TIMER_EN
        cpu_write(16'hFF02, 8'h00, 1'b1);
        repeat (16'h1234) @(posedge clk);
        #1;
        bus.addr = 16'hFF02;
        #1;
        check("timer_lo", bus.rdata, 8'h34);
        cycle();
        bus.addr = 16'hFF03;
        #1;
        check("timer_hi", bus.rdata, 8'h12);
`else
        check_read("no_timer_lo", 16'hFF02);
        check("no_timer_lo_val", bus.rdata, 8'hEA);
        cpu_write(16'hFF03, 8'h55, 1'b1);
        check_read("no_timer_hi", 16'hFF03);
        check("no_timer_hi_val", bus.rdata, 8'hEA);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bus_memory.md
# bus_memory

- Memory-side responder for the CPU core's 16-bit address / 8-bit data bus.
- Returns read data for every CPU address and accepts CPU writes into on-chip RAM.
- Contains a byte-stream program loader that holds the CPU in reset while it fills RAM from address 0x0000, then releases it.
- Sits between the CPU core and the board-level loader (UART/host bridge); the CPU's `din` is driven from this block's `rdata`.

## Interface
Parameters:
- RAM_AW, 10, RAM address width; RAM occupies 0x0000..2^RAM_AW-1, 2^RAM_AW bytes.
- FILL_BYTE, 8'hEA, value returned for unmapped reads (NOP opcode).

Ports (reset is asynchronous and active-high; clock `clk`, reset `reset`):
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- addr  in  16  CPU bus address.
- we  in  1  CPU write strobe, sampled on rising edge.
- wdata  in  8  CPU write data.
- rdata  out  8  read data to CPU `din`.
- cpu_reset  out  1  reset request to CPU core, active-high.
- ld_start  in  1  one-cycle pulse: begin a program load.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_last  in  1  marks final byte of the image, qualified by ld_valid.
- ld_ready  out  1  block accepts a loader byte this cycle.
- ld_busy  out  1  load in progress.
- ld_err  out  1  sticky: image exceeded RAM size.

## Operation
- Address map: 0x0000..2^RAM_AW-1 RAM; 0xFF00 status (bit0 ld_busy, bit1 ld_err, bits7:2 zero); timer at 0xFF02/0xFF03 when configured; everything else reads FILL_BYTE, writes ignored. No mirroring.
- Reads: rdata is a combinational function of addr and current contents (zero read latency).
- CPU writes: on a rising edge with we=1, addr in RAM, state IDLE -> mem[addr] <= wdata. Writing 0xFF00 with bit1=1 clears ld_err. All other addresses ignore writes.
- FSM states:
  - IDLE: cpu_reset=0, ld_ready=0, ld_busy=0.
  - LOAD: cpu_reset=1, ld_ready=1, ld_busy=1.
  - RELEASE: cpu_reset=1, ld_ready=0, ld_busy=1; lasts exactly one cycle, then IDLE.
- Transitions:
  - IDLE -> LOAD on ld_start; pointer ptr (RAM_AW+1 bits) cleared to 0 and ld_err cleared.
  - LOAD: each ld_valid&&ld_ready beat writes ld_data to mem[ptr] and ptr increments.
  - LOAD -> RELEASE on the beat carrying ld_last.
- Overflow: a beat with ptr == 2^RAM_AW is dropped (no write, no wrap to 0) and sets ld_err. LOAD continues until ld_last.
- ld_start while LOAD or RELEASE: ignored.
- CPU we while not IDLE: ignored; the loader has sole write access.
- Memory contents are not reset.

## Timing
- Reset values: FSM IDLE, cpu_reset=1 while reset is high, 0 after release. ld_ready=0, ld_busy=0, ld_err=0, ptr=0, timer=0. rdata reflects addr immediately.
- ld_start at edge N -> ld_ready, ld_busy, cpu_reset high after edge N. The first byte is accepted at edge N+1 if ld_valid=1.
- Throughput: one byte per cycle. ld_valid may stall arbitrarily; ld_ready stays 1 throughout LOAD.
- ld_last beat at edge M -> RELEASE after M. cpu_reset falls after edge M+1; the CPU sees its first non-reset edge at M+2.
- A CPU write at edge K is visible on rdata immediately after edge K, so a read of the same address at cycle K+1 returns the new value.
- Async reset mid-load: FSM returns to IDLE at once. Bytes already written stay in RAM.

## Configuration
- `BUS_MEMORY_TIMER_EN` defined:
  - 16-bit free-running cycle counter, reset to 0, increments every clk, wraps 0xFFFF->0x0000.
  - Reading 0xFF02 returns the low byte and snapshots the high byte into a holding register on that same edge (when the CPU read is qualified by we=0 and state IDLE).
  - 0xFF03 returns the holding register.
  - Writes to either address clear the counter and the holding register.
- Undefined: no counter logic; 0xFF02/0xFF03 read FILL_BYTE, writes ignored.

## Test plan
- Reset, then read 0x0400, 0xFF01 and 0xFF00 -> 0xEA, 0xEA, 0x00; cpu_reset=0 after reset drops.
- Pulse ld_start, stream A9 05 69 03 with ld_last on the 4th byte and a 2-cycle ld_valid gap after byte 2 -> mem[0..3]=A9,05,69,03; cpu_reset high from start through one cycle after the last beat; ld_busy then 0.
- Load 2^RAM_AW+2 bytes -> first 2^RAM_AW stored, mem[0] unchanged by extra bytes, ld_err=1, 0xFF00 reads 0x02; write 0x02 to 0xFF00 -> reads 0x00.
- CPU write 0x5A to 0x0010, then read next cycle -> 0x5A. Same write with we during LOAD -> mem[0x0010] unchanged.
- Assert async reset two bytes into a load -> ld_busy=0 and cpu_reset=1 immediately; after release the FSM is IDLE and the second byte is retained.
- With BUS_MEMORY_TIMER_EN: run 0x1234 cycles, read 0xFF02 then 0xFF03 -> 0x34, 0x12 (snapshot consistent). Without the macro both read 0xEA.
